// File: rtl/fraction_reducer.sv
// Reduces num/den by their gcd g using one shared restoring divider (num first, then den).
// Flags g == 0 or a g that leaves a remainder on either operand.
module fraction_reducer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    input  logic [W-1:0] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] num_r,
    output logic [W-1:0] den_r,
    output logic         err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV_NUM,
        DIV_DEN,
        DONE
    } state_t;

    state_t         state_q;
    logic [W-1:0]   num_q, den_q, g_q;
    logic [W-1:0]   rem_q, quo_q;
    logic [CW-1:0]  bit_q;
    logic [W-1:0]   num_r_q, den_r_q;
    logic           err_q, in_ready_q, out_valid_q;

    logic [W-1:0]   dividend_d;
    logic [W:0]     rem_shift_d;
    logic           ge_d;
    logic [W-1:0]   rem_d, quo_d;

    // One restoring-division step. The shifted remainder is W+1 bits, but once it
    // is >= g the difference is < g, so the low W bits of the subtraction are exact.
    always_comb begin
        // NOTE: every always_comb output gets a value before any condition, so no latch can be inferred.
        dividend_d  = (state_q == DIV_DEN) ? den_q : num_q;
        rem_shift_d = {rem_q, dividend_d[bit_q]};
        ge_d        = (rem_shift_d >= {1'b0, g_q});
        rem_d       = ge_d ? (rem_shift_d[W-1:0] - g_q) : rem_shift_d[W-1:0];
        quo_d       = quo_q;
        quo_d[bit_q] = ge_d;
    end

    // NOTE: state is updated only with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num_q       <= '0;
            den_q       <= '0;
            g_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            bit_q       <= '0;
            num_r_q     <= '0;
            den_r_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        num_q      <= num;
                        den_q      <= den;
                        g_q        <= g;
                        in_ready_q <= 1'b0;
                        if (g == '0) begin
                            num_r_q     <= num;
                            den_r_q     <= den;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            bit_q   <= CW'(W - 1);
                            rem_q   <= '0;
                            quo_q   <= '0;
                            err_q   <= 1'b0;
                            state_q <= DIV_NUM;
                        end
                    end
                end
                DIV_NUM, DIV_DEN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    bit_q <= bit_q - CW'(1);
                    if (bit_q == '0) begin
                        // Last step of this operand: a leftover remainder means g did not divide it.
                        err_q <= err_q | (rem_d != '0);
                        rem_q <= '0;
                        bit_q <= CW'(W - 1);
                        if (state_q == DIV_NUM) begin
                            num_r_q <= quo_d;
                            state_q <= DIV_DEN;
                        end else begin
                            den_r_q     <= quo_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign num_r     = num_r_q;
    assign den_r     = den_r_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fraction_reducer.sv
// Self-checking bench for fraction_reducer: fixed vectors, reset/backpressure
// sequences, and random operand pairs checked against an arithmetic model.
module tb_fraction_reducer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] num, den, g;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] num_r, den_r;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] g;
        logic [W-1:0] exp_num;
        logic [W-1:0] exp_den;
        logic         exp_err;
        int           hold;
    } vec_t;

    fraction_reducer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .num_r     (num_r),
        .den_r     (den_r),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // Expected result straight from the arithmetic definition of a reduced fraction.
    function automatic vec_t model(input logic [W-1:0] n, input logic [W-1:0] d,
                                   input logic [W-1:0] gg, input int hold);
        vec_t v;
        v.num = n; v.den = d; v.g = gg; v.hold = hold;
        if (gg == 0) begin
            v.exp_num = n; v.exp_den = d; v.exp_err = 1'b1;
        end else begin
            v.exp_num = W'(int'(n) / int'(gg));
            v.exp_den = W'(int'(d) / int'(gg));
            v.exp_err = ((int'(n) % int'(gg)) != 0) || ((int'(d) % int'(gg)) != 0);
        end
        return v;
    endfunction

    // Accept one operand set, time the result, check it, optionally hold off the
    // consumer for v.hold cycles while checking stability, then complete the transfer.
    task automatic run_txn(input vec_t v, input string tag,
                           output logic [W-1:0] rn, output logic [W-1:0] rd, output logic re);
        int waited = 0;
        int lat = 0;
        rn = '0; rd = '0; re = 1'b0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check({tag, " in_ready_timeout"}, 32'(in_ready), 32'd1);
            return;
        end
        num = v.num; den = v.den; g = v.g;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num = W'($urandom); den = W'($urandom); g = W'($urandom);
        // The first sample after the accept edge counts as 1; with g != 0 the
        // 2W division cycles come first, so DONE is sample 2W+1.
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, " latency"}, 32'(lat), (v.g == 0) ? 32'd1 : 32'(2 * W + 1));
        check({tag, " num_r"}, 32'(num_r), 32'(v.exp_num));
        check({tag, " den_r"}, 32'(den_r), 32'(v.exp_den));
        check({tag, " err"}, 32'(err), 32'(v.exp_err));
        rn = num_r; rd = den_r; re = err;
        for (int i = 0; i < v.hold; i++) begin
            if (v.hold >= 4 && i == v.hold / 2) begin
                in_valid = 1'b1;
                num = ~v.num; den = ~v.den; g = 8'd1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, " hold_num"}, 32'(num_r), 32'(rn));
            check({tag, " hold_den"}, 32'(den_r), 32'(rd));
            check({tag, " hold_err"}, 32'(err), 32'(re));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " post_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t         vecs[12];
        vec_t         v;
        logic [W-1:0] rn, rd, n, d;
        logic         re;
        int           seen_valid;

        vecs[0]  = '{8'h44, 8'h35, 8'h01, 8'h44, 8'h35, 1'b0, 0};
        vecs[1]  = '{8'h34, 8'h48, 8'h04, 8'h0D, 8'h12, 1'b0, 0};
        vecs[2]  = '{8'h14, 8'h18, 8'h04, 8'h05, 8'h06, 1'b0, 0};
        vecs[3]  = '{8'h10, 8'h05, 8'h01, 8'h10, 8'h05, 1'b0, 0};
        vecs[4]  = '{8'h20, 8'h08, 8'h08, 8'h04, 8'h01, 1'b0, 0};
        vecs[5]  = '{8'h34, 8'h48, 8'h00, 8'h34, 8'h48, 1'b1, 0};
        vecs[6]  = '{8'h34, 8'h48, 8'h03, 8'h11, 8'h18, 1'b1, 0};
        vecs[7]  = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 1'b0, 0};
        vecs[8]  = '{8'h00, 8'h05, 8'h05, 8'h00, 8'h01, 1'b0, 0};
        vecs[9]  = '{8'hFF, 8'h01, 8'h01, 8'hFF, 8'h01, 1'b0, 0};
        vecs[10] = '{8'h14, 8'h18, 8'h04, 8'h05, 8'h06, 1'b0, 10};
        vecs[11] = '{8'h34, 8'h48, 8'h00, 8'h34, 8'h48, 1'b1, 10};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        num = '0; den = '0; g = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset num_r", 32'(num_r), 32'd0);
        check("reset den_r", 32'(den_r), 32'd0);
        check("reset err", 32'(err), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i), rn, rd, re);
        end

        // Reset in the middle of DIV_NUM, after an erroring result left nonzero outputs.
        @(negedge clk);
        num = 8'h34; den = 8'h48; g = 8'h04; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset num_r", 32'(num_r), 32'd0);
        check("midreset den_r", 32'(den_r), 32'd0);
        check("midreset err", 32'(err), 32'd0);
        seen_valid = 0;
        repeat (2 * W + 4) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("midreset discarded", 32'(seen_valid), 32'd0);
        run_txn(vecs[1], "after_reset", rn, rd, re);

        for (int i = 0; i < 1000; i++) begin
            n = W'($urandom_range(0, 255));
            d = W'($urandom_range(0, 255));
            if (n == 0 && d == 0) d = 8'd1;
            v = model(n, d, gcd(n, d), $urandom_range(0, 3));
            run_txn(v, $sformatf("rnd%0d", i), rn, rd, re);
            check($sformatf("rnd%0d num_prod", i), 32'(int'(rn) * int'(v.g)), 32'(n));
            check($sformatf("rnd%0d den_prod", i), 32'(int'(rd) * int'(v.g)), 32'(d));
            check($sformatf("rnd%0d err0", i), 32'(re), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
